// File: rtl/fir_pkg.sv
// Shared FIR constants and types: tap count, coefficient/address widths,
// the commit FSM state encoding and a tap-address range check.
package fir_pkg;

    localparam int NUM_TAP = 10;
    localparam int COEFF_W = 16;
    localparam int ADDR_W  = 4;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_TAP - 1);

    typedef logic signed [COEFF_W-1:0] coeff_t;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_e;

    function automatic logic addrValid(input logic [ADDR_W-1:0] addr);
        return addr <= LAST_ADDR;
    endfunction

endpackage

// File: rtl/coeff_bank_ctrl_if.sv
// Host register-bus bundle for the coefficient bank: chip select, read/write
// strobes, address/data, and the registered read/error returns.
interface coeff_bank_ctrl_if;
    import fir_pkg::*;

    logic                iCsn;
    logic                iWrEn;
    logic                iRdEn;
    logic [ADDR_W-1:0]   iAddr;
    coeff_t              iWrDt;
    coeff_t              oRdDt;
    logic                oRdValid;
    logic                oErr;

    modport master (
        output iCsn, iWrEn, iRdEn, iAddr, iWrDt,
        input  oRdDt, oRdValid, oErr
    );

    modport slave (
        input  iCsn, iWrEn, iRdEn, iAddr, iWrDt,
        output oRdDt, oRdValid, oErr
    );

endinterface

// File: rtl/coeff_regfile.sv
// Shadow coefficient register file: one write port, one registered read port,
// and the whole bank exposed so the controller can copy it in a single cycle.
module coeff_regfile
    import fir_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wrEn_i,
    input  logic [ADDR_W-1:0] wrAddr_i,
    input  coeff_t            wrDt_i,
    input  logic              rdEn_i,
    input  logic [ADDR_W-1:0] rdAddr_i,
    output coeff_t            rdDt_o,
    output logic              rdValid_o,
    output coeff_t            bank_o [NUM_TAP]
);

    coeff_t mem_q [NUM_TAP];
    coeff_t rdDt_q;
    coeff_t rdDt_d;
    logic   rdValid_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_TAP; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wrEn_i && addrValid(wrAddr_i)) begin
            mem_q[wrAddr_i] <= wrDt_i;
        end
    end

    // Out-of-range reads still complete, returning zero.
    always_comb begin
        rdDt_d = rdDt_q;
        if (rdEn_i) begin
            rdDt_d = addrValid(rdAddr_i) ? mem_q[rdAddr_i] : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdDt_q    <= '0;
            rdValid_q <= 1'b0;
        end else begin
            rdDt_q    <= rdDt_d;
            rdValid_q <= rdEn_i;
        end
    end

    assign rdDt_o    = rdDt_q;
    assign rdValid_o = rdValid_q;
    assign bank_o    = mem_q;

endmodule

// File: rtl/coeff_bank_ctrl.sv
// Coefficient bank controller: host writes go to a shadow bank, and a commit
// copies shadow to the active MAC taps only on a sample strobe.
module coeff_bank_ctrl
    import fir_pkg::*;
(
    input  logic               iClk_12M,
    input  logic               iRsn,
    input  logic               iEnSample_300k,
    input  logic               iCommit,
    coeff_bank_ctrl_if.slave   host,
    output logic               oBusy,
    output logic               oCommitDone,
    output coeff_t             oCoeff1,
    output coeff_t             oCoeff2,
    output coeff_t             oCoeff3,
    output coeff_t             oCoeff4,
    output coeff_t             oCoeff5,
    output coeff_t             oCoeff6,
    output coeff_t             oCoeff7,
    output coeff_t             oCoeff8,
    output coeff_t             oCoeff9,
    output coeff_t             oCoeff10
);

    state_e state_q;
    state_e state_d;
    logic   copy;
    logic   wrReq;
    logic   rdReq;
    logic   wrAccept;
    logic   err_d;
    logic   err_q;
    logic   commitDone_q;
    coeff_t active_q [NUM_TAP];
    coeff_t shadow   [NUM_TAP];

    // A simultaneous read is dropped in favour of the write.
    assign wrReq    = !host.iCsn && host.iWrEn;
    assign rdReq    = !host.iCsn && host.iRdEn && !host.iWrEn;
    assign wrAccept = wrReq && addrValid(host.iAddr) && (state_q == IDLE);

    coeff_regfile uRegfile (
        .clk_i     (iClk_12M),
        .rst_n_i   (iRsn),
        .wrEn_i    (wrAccept),
        .wrAddr_i  (host.iAddr),
        .wrDt_i    (host.iWrDt),
        .rdEn_i    (rdReq),
        .rdAddr_i  (host.iAddr),
        .rdDt_o    (host.oRdDt),
        .rdValid_o (host.oRdValid),
        .bank_o    (shadow)
    );

    // The strobe that arrives with the commit request is not used for the copy.
    always_comb begin
        state_d = state_q;
        copy    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (iCommit) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (iEnSample_300k) begin
                    copy    = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
        err_d = (wrReq && (!addrValid(host.iAddr) || (state_q == PEND) || host.iRdEn))
              || (rdReq && !addrValid(host.iAddr));
    end

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            state_q      <= IDLE;
            commitDone_q <= 1'b0;
            err_q        <= 1'b0;
            for (int i = 0; i < NUM_TAP; i++) begin
                active_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            commitDone_q <= copy;
            err_q        <= err_d;
            if (copy) begin
                active_q <= shadow;
            end
        end
    end

    assign oBusy       = (state_q == PEND);
    assign oCommitDone = commitDone_q;
    assign host.oErr   = err_q;

    assign oCoeff1  = active_q[0];
    assign oCoeff2  = active_q[1];
    assign oCoeff3  = active_q[2];
    assign oCoeff4  = active_q[3];
    assign oCoeff5  = active_q[4];
    assign oCoeff6  = active_q[5];
    assign oCoeff7  = active_q[6];
    assign oCoeff8  = active_q[7];
    assign oCoeff9  = active_q[8];
    assign oCoeff10 = active_q[9];

endmodule

// File: tb/tb_coeff_bank_ctrl.sv
// Directed bench for coeff_bank_ctrl: host writes/reads, commit timing against
// the sample strobe, access rejection, and asynchronous reset during a commit.
module tb_coeff_bank_ctrl;
    import fir_pkg::*;

    logic   iClk_12M = 1'b0;
    logic   iRsn;
    logic   iEnSample_300k;
    logic   iCommit;
    logic   oBusy;
    logic   oCommitDone;
    coeff_t oCoeff [NUM_TAP];

    int nCheck = 0;
    int nPass  = 0;
    int nFail  = 0;

    coeff_bank_ctrl_if hostIf ();

    coeff_bank_ctrl dut (
        .iClk_12M       (iClk_12M),
        .iRsn           (iRsn),
        .iEnSample_300k (iEnSample_300k),
        .iCommit        (iCommit),
        .host           (hostIf),
        .oBusy          (oBusy),
        .oCommitDone    (oCommitDone),
        .oCoeff1        (oCoeff[0]),
        .oCoeff2        (oCoeff[1]),
        .oCoeff3        (oCoeff[2]),
        .oCoeff4        (oCoeff[3]),
        .oCoeff5        (oCoeff[4]),
        .oCoeff6        (oCoeff[5]),
        .oCoeff7        (oCoeff[6]),
        .oCoeff8        (oCoeff[7]),
        .oCoeff9        (oCoeff[8]),
        .oCoeff10       (oCoeff[9])
    );

    always #5 iClk_12M = ~iClk_12M;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nCheck++;
        assert (obs === exp) nPass++;
        else begin
            nFail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of bus/control inputs, then returns them idle 1 ns after the edge.
    task automatic applyStimulus(input logic csn, input logic wr, input logic rd,
                                 input logic [3:0] addr, input logic [15:0] data,
                                 input logic commit, input logic strobe);
        hostIf.iCsn    = csn;
        hostIf.iWrEn   = wr;
        hostIf.iRdEn   = rd;
        hostIf.iAddr   = addr;
        hostIf.iWrDt   = data;
        iCommit        = commit;
        iEnSample_300k = strobe;
        @(posedge iClk_12M);
        #1;
        hostIf.iCsn    = 1'b1;
        hostIf.iWrEn   = 1'b0;
        hostIf.iRdEn   = 1'b0;
        iCommit        = 1'b0;
        iEnSample_300k = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge iClk_12M);
        #1;
    endtask

    initial begin
        logic [15:0] val;
        iRsn           = 1'b0;
        iEnSample_300k = 1'b0;
        iCommit        = 1'b0;
        hostIf.iCsn    = 1'b1;
        hostIf.iWrEn   = 1'b0;
        hostIf.iRdEn   = 1'b0;
        hostIf.iAddr   = '0;
        hostIf.iWrDt   = '0;
        idleCycles(2);
        checkOutput("rst_coeff1", oCoeff[0], 16'h0000);
        checkOutput("rst_busy", {15'b0, oBusy}, 16'h0000);
        checkOutput("rst_rdvalid", {15'b0, hostIf.oRdValid}, 16'h0000);
        checkOutput("rst_err", {15'b0, hostIf.oErr}, 16'h0000);
        checkOutput("rst_done", {15'b0, oCommitDone}, 16'h0000);
        checkOutput("rst_rddt", hostIf.oRdDt, 16'h0000);
        iRsn = 1'b1;
        idleCycles(1);

        for (int i = 0; i < NUM_TAP; i++) begin
            val = (i % 2 == 0) ? 16'(i + 1) : 16'(-(i + 1));
            applyStimulus(1'b0, 1'b1, 1'b0, 4'(i), val, 1'b0, 1'b0);
        end
        checkOutput("wr_noerr", {15'b0, hostIf.oErr}, 16'h0000);
        checkOutput("nocommit_coeff1", oCoeff[0], 16'h0000);
        checkOutput("nocommit_coeff10", oCoeff[9], 16'h0000);

        applyStimulus(1'b0, 1'b0, 1'b1, 4'd3, 16'h0, 1'b0, 1'b0);
        checkOutput("rd3_valid", {15'b0, hostIf.oRdValid}, 16'h0001);
        checkOutput("rd3_data", hostIf.oRdDt, 16'hFFFC);
        idleCycles(1);
        checkOutput("rd3_valid_drop", {15'b0, hostIf.oRdValid}, 16'h0000);
        checkOutput("rd3_data_hold", hostIf.oRdDt, 16'hFFFC);

        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0);
        checkOutput("commit_busy", {15'b0, oBusy}, 16'h0001);
        idleCycles(20);
        checkOutput("pend_busy", {15'b0, oBusy}, 16'h0001);
        checkOutput("pend_coeff1", oCoeff[0], 16'h0000);
        checkOutput("pend_done", {15'b0, oCommitDone}, 16'h0000);

        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 16'h7FFF, 1'b0, 1'b0);
        checkOutput("pend_wr_err", {15'b0, hostIf.oErr}, 16'h0001);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 16'h0, 1'b0, 1'b0);
        checkOutput("pend_rd_err", {15'b0, hostIf.oErr}, 16'h0000);
        checkOutput("pend_rd_valid", {15'b0, hostIf.oRdValid}, 16'h0001);
        checkOutput("pend_rd_data", hostIf.oRdDt, 16'h0001);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd12, 16'h1111, 1'b0, 1'b0);
        checkOutput("pend_wr12_err", {15'b0, hostIf.oErr}, 16'h0001);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0);
        checkOutput("pend_recommit_err", {15'b0, hostIf.oErr}, 16'h0000);

        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
        checkOutput("copy_coeff1", oCoeff[0], 16'h0001);
        checkOutput("copy_coeff4", oCoeff[3], 16'hFFFC);
        checkOutput("copy_coeff10", oCoeff[9], 16'hFFF6);
        checkOutput("copy_done", {15'b0, oCommitDone}, 16'h0001);
        checkOutput("copy_busy", {15'b0, oBusy}, 16'h0000);
        idleCycles(1);
        checkOutput("copy_done_drop", {15'b0, oCommitDone}, 16'h0000);
        checkOutput("copy_coeff1_hold", oCoeff[0], 16'h0001);

        applyStimulus(1'b0, 1'b1, 1'b0, 4'd12, 16'h0005, 1'b0, 1'b0);
        checkOutput("idle_wr12_err", {15'b0, hostIf.oErr}, 16'h0001);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd12, 16'h0, 1'b0, 1'b0);
        checkOutput("rd12_data", hostIf.oRdDt, 16'h0000);
        checkOutput("rd12_valid", {15'b0, hostIf.oRdValid}, 16'h0001);
        checkOutput("rd12_err", {15'b0, hostIf.oErr}, 16'h0001);

        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd1, 16'h0055, 1'b0, 1'b1);
        checkOutput("strobe_wr_err", {15'b0, hostIf.oErr}, 16'h0001);
        checkOutput("strobe_wr_done", {15'b0, oCommitDone}, 16'h0001);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd1, 16'h0, 1'b0, 1'b0);
        checkOutput("strobe_wr_rd1", hostIf.oRdDt, 16'hFFFE);

        applyStimulus(1'b0, 1'b1, 1'b0, 4'd2, 16'h0100, 1'b0, 1'b0);
        checkOutput("wr2_err", {15'b0, hostIf.oErr}, 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b1);
        checkOutput("same_cycle_done", {15'b0, oCommitDone}, 16'h0000);
        checkOutput("same_cycle_busy", {15'b0, oBusy}, 16'h0001);
        checkOutput("same_cycle_coeff3", oCoeff[2], 16'h0003);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
        checkOutput("next_strobe_coeff3", oCoeff[2], 16'h0100);
        checkOutput("next_strobe_done", {15'b0, oCommitDone}, 16'h0001);

        applyStimulus(1'b0, 1'b1, 1'b1, 4'd5, 16'h1234, 1'b0, 1'b0);
        checkOutput("wrrd_rdvalid", {15'b0, hostIf.oRdValid}, 16'h0000);
        checkOutput("wrrd_err", {15'b0, hostIf.oErr}, 16'h0001);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd5, 16'h0, 1'b0, 1'b0);
        checkOutput("wrrd_rd5", hostIf.oRdDt, 16'h1234);

        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0);
        idleCycles(3);
        checkOutput("prerst_busy", {15'b0, oBusy}, 16'h0001);
        #2;
        iRsn = 1'b0;
        #1;
        checkOutput("arst_coeff3", oCoeff[2], 16'h0000);
        checkOutput("arst_coeff1", oCoeff[0], 16'h0000);
        checkOutput("arst_busy", {15'b0, oBusy}, 16'h0000);
        checkOutput("arst_rddt", hostIf.oRdDt, 16'h0000);
        idleCycles(1);
        iRsn = 1'b1;
        idleCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
        checkOutput("postrst_done", {15'b0, oCommitDone}, 16'h0000);
        checkOutput("postrst_coeff1", oCoeff[0], 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd5, 16'h0, 1'b0, 1'b0);
        checkOutput("postrst_rd5", hostIf.oRdDt, 16'h0000);

        $display("%0d/%0d checks passed", nPass, nCheck);
        $finish;
    end

endmodule
